// File: rtl/demux_pkg.sv
// Shared types and constants for the clocked 1-to-4 demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SEL_W     = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_OUT0 = 2'd0;
    localparam sel_t SEL_OUT1 = 2'd1;
    localparam sel_t SEL_OUT2 = 2'd2;
    localparam sel_t SEL_OUT3 = 2'd3;

endpackage : demux_pkg

// File: rtl/demux_decoder.sv
// Combinational lane-select decoder: 2-bit select to one-hot lane enable.
module demux_decoder
    import demux_pkg::*;
(
    input  sel_t                 sel_i,
    output logic [NUM_LANES-1:0] en_o
);

    always_comb begin
        en_o = '0;
        case (sel_i)
            SEL_OUT0: en_o[0] = 1'b1;
            SEL_OUT1: en_o[1] = 1'b1;
            SEL_OUT2: en_o[2] = 1'b1;
            SEL_OUT3: en_o[3] = 1'b1;
            default:  en_o    = '0;
        endcase
    end

endmodule : demux_decoder

// File: rtl/demux_4_1.sv
// Clocked 1-to-4 demultiplexer with registered lanes and async active-high reset.
// Define DEMUX_HOLD_EN to make non-selected lanes keep their value instead of clearing.
module demux_4_1
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3
);

    logic [NUM_LANES-1:0] lane_en;
    logic [WIDTH-1:0]     lane_d [NUM_LANES];
    logic [WIDTH-1:0]     lane_q [NUM_LANES];

    demux_decoder u_decoder (
        .sel_i (sel_t'(sel)),
        .en_o  (lane_en)
    );

    // Selected lane takes the payload; the others clear or hold by build option.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef DEMUX_HOLD_EN
            lane_d[i] = lane_q[i];
`else
            lane_d[i] = '0;
`endif
            if (lane_en[i]) begin
                lane_d[i] = data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign out0 = lane_q[0];
    assign out1 = lane_q[1];
    assign out2 = lane_q[2];
    assign out3 = lane_q[3];

endmodule : demux_4_1

// File: tb/tb_demux_4_1.sv
// Self-checking bench for demux_4_1: WIDTH=8 and WIDTH=1 instances against a lane-array model.
module tb_demux_4_1;

`ifdef DEMUX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [1:0] sel;
    logic [7:0] o0, o1, o2, o3;
    logic       n0, n1, n2, n3;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  exp_q [4];

    always #5 clk = ~clk;

    demux_4_1 #(.WIDTH(8)) u_dut (
        .clk (clk), .rst (rst), .data (data), .sel (sel),
        .out0 (o0), .out1 (o1), .out2 (o2), .out3 (o3)
    );

    demux_4_1 #(.WIDTH(1)) u_dut_w1 (
        .clk (clk), .rst (rst), .data (data[0]), .sel (sel),
        .out0 (n0), .out1 (n1), .out2 (n2), .out3 (n3)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] wide_out(input int i);
        case (i)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return o3;
        endcase
    endfunction

    function automatic logic narrow_out(input int i);
        case (i)
            0:       return n0;
            1:       return n1;
            2:       return n2;
            default: return n3;
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s w8 lane%0d", tag, i), wide_out(i), exp_q[i]);
            check($sformatf("%s w1 lane%0d", tag, i), {7'b0, narrow_out(i)}, {7'b0, exp_q[i][0]});
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) exp_q[i] = 8'h00;
    endtask

    // Reference behaviour at a rising edge: addressed lane gets data, others clear or hold.
    task automatic model_edge();
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i == int'(sel)) exp_q[i] = data;
                else if (!HOLD)     exp_q[i] = 8'h00;
            end
        end
    endtask

    task automatic step(input logic [7:0] d, input logic [1:0] s, input string tag);
        data = d;
        sel  = s;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        data = 8'h01;
        sel  = 2'd2;
        model_clear();
        #2;
        check_all("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_all("rst_held");

        rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_all("rst_release");
        check("rst_release out2", o2, 8'h01);

        for (int s = 0; s < 4; s++) step(8'h01, 2'(s), $sformatf("sweep sel%0d", s));

        step(8'h01, 2'd0, "lat pre");
        #3;
        sel = 2'd3;
        #1;
        check_all("lat midcycle");
        check("lat mid out0", o0, 8'h01);
        @(posedge clk);
        model_edge();
        #1;
        check_all("lat post");
        check("lat post out3", o3, 8'h01);

        step(8'h01, 2'd1, "arst pre");
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_all("arst mid");
        check("arst out1", o1, 8'h00);
        rst = 1'b0;

        step(8'hA5, 2'd1, "w8 a5");
        step(8'h3C, 2'd2, "w8 3c");
        check("w8 out1 after 3c", o1, HOLD ? 8'hA5 : 8'h00);
        check("w8 out2 after 3c", o2, 8'h3C);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(19) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_clear();
                check_all("rnd arst");
                rst = 1'b0;
            end
            step(8'($urandom), 2'($urandom_range(3)), $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_4_1

// File: doc/demux_4_1.md
# demux_4_1

Clocked 1-to-4 demultiplexer: routes one data input to one of four outputs selected by a 2-bit select, with all outputs registered on the rising clock edge. It sits between a single producer and four consumer lanes and steers the producer's data to the addressed lane. Non-selected lanes are driven to zero, or hold their last value when the hold option is compiled in.

## Interface
- `WIDTH`, default 1, bit width of `data` and of each output.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high; one clock domain only.
- `data`  input  WIDTH  payload to route.
- `sel`  input  2  lane select: 0→`out0`, 1→`out1`, 2→`out2`, 3→`out3`.
- `out0`  output  WIDTH  lane 0, registered.
- `out1`  output  WIDTH  lane 1, registered.
- `out2`  output  WIDTH  lane 2, registered.
- `out3`  output  WIDTH  lane 3, registered.

## Operation
- Decode `sel` to a 4-bit one-hot lane enable.
- On each rising `clk` edge with `rst` low, the selected lane register loads `data`.
- Without `DEMUX_HOLD_EN`, every non-selected lane register loads 0.
- Exactly one lane carries `data` after each edge. All other lanes are 0 (default build) or unchanged (hold build).
- `sel` is always one of four legal values, so there is no illegal state.
- X/Z on `sel` is not required to be handled. The verification bench never drives it.
- `data` = 0 routed to a lane drives that lane to 0. This is indistinguishable from "not selected" in the default build.
- There is no enable or handshake. The block captures on every clock.

## Timing
- Reset: `rst` high clears `out0`–`out3` to 0 immediately (asynchronously), independent of `clk`. Outputs stay 0 while `rst` is high.
- Reset release: the first rising edge with `rst` low captures `data`/`sel`. There is no extra dead cycle.
- Reset asserted mid-operation clears all lanes at once. Any in-flight capture is discarded.
- Latency: exactly 1 clock. Outputs reflect the `data`/`sel` sampled at the previous rising edge.
- `sel` and `data` changing between edges have no effect on the outputs until the next edge.
- A `sel` change drives the old lane to 0 and the new lane to `data` on the same edge (default build). There is no cycle with two active lanes.
- Throughput: one routing decision per cycle.

## Configuration
- `DEMUX_HOLD_EN` defined: non-selected lanes keep their previous registered value. Only the selected lane updates. Reset still clears all lanes to 0.
- `DEMUX_HOLD_EN` undefined (default): non-selected lanes are cleared to 0 every cycle.

## Structure
- Package `demux_pkg`:
  - typedef `sel_t` (2-bit lane select).
  - constants `SEL_OUT0`=0, `SEL_OUT1`=1, `SEL_OUT2`=2, `SEL_OUT3`=3.
  - constant `NUM_LANES`=4.
- Sub-module `demux_decoder`: combinational `sel_t` → 4-bit one-hot enable.
- Top level: four WIDTH-bit lane registers with async reset, each gated by its one-hot bit.

## Test plan
- Reset: `rst`=1 with `data`=1, `sel`=2, clock running → all outputs 0. Release `rst` → next edge gives `out2`=1, others 0.
- Sweep, WIDTH=1, `data`=1: `sel` 0,1,2,3 held one cycle each → after each edge only `out0`, then `out1`, `out2`, `out3` is 1, others 0.
- Latency: change `sel` 0→3 mid-cycle → `out0`=1 until the next edge, then `out3`=1 and `out0`=0. No intermediate glitch state at edges.
- Async reset mid-stream: assert `rst` between edges while `out1`=1 → `out1` drops to 0 before the next edge.
- WIDTH=8: `data`=0xA5, `sel`=1, then `data`=0x3C, `sel`=2 → `out1`=0xA5 then `out2`=0x3C. Default build: `out1`=0 on the second edge. `DEMUX_HOLD_EN` build: `out1` stays 0xA5.
